// File: rtl/debug_frame_tx.sv
// Serialises a snapshot of the MIPS pc and pipeline latches into a UART byte frame.
// Define DEBUG_FRAME_CHECKSUM_EN to append an XOR checksum trailer after the payload.
module debug_frame_tx #(
  parameter int LEN    = 32,
  parameter int NB_L12 = 8,
  parameter int NB_L23 = 16,
  parameter int NB_L34 = 16,
  parameter int NB_L45 = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [LEN-1:0]        pc,
  input  logic [NB_L12*8-1:0]   Latches_1_2,
  input  logic [NB_L23*8-1:0]   Latches_2_3,
  input  logic [NB_L34*8-1:0]   Latches_3_4,
  input  logic [NB_L45*8-1:0]   Latches_4_5,
  input  logic                  tx_done,
  output logic                  tx_start,
  output logic [7:0]            data_out,
  output logic                  busy,
  output logic                  done
);

  // LEN is expected to be a whole number of bytes
  localparam int P      = LEN / 8 + NB_L12 + NB_L23 + NB_L34 + NB_L45;
  localparam int SNAP_W = P * 8;
  localparam int CNT_W  = $clog2(P + 3);
  localparam int IDX_W  = $clog2(SNAP_W);
`ifdef DEBUG_FRAME_CHECKSUM_EN
  localparam int LAST   = P + 1;
`else
  localparam int LAST   = P;
`endif

  typedef enum logic [1:0] {IDLE, SEND, WAIT, FINISH} state_t;

  state_t             state;
  logic [CNT_W-1:0]   byte_cnt;
  logic [SNAP_W-1:0]  snapshot;
  logic [IDX_W-1:0]   payload_base;
  logic [7:0]         cur_byte;
  logic               is_payload;
`ifdef DEBUG_FRAME_CHECKSUM_EN
  logic [7:0]         checksum;
`endif

  // Counter 0 is the header, 1..P walk the snapshot from its top byte downwards
  always_comb begin
    is_payload   = (byte_cnt != '0) && (int'(byte_cnt) <= P);
    payload_base = '0;
    if (is_payload)
      payload_base = IDX_W'(SNAP_W - 8 * int'(byte_cnt));
    if (byte_cnt == '0)
      cur_byte = 8'hA5;
`ifdef DEBUG_FRAME_CHECKSUM_EN
    else if (byte_cnt == CNT_W'(LAST))
      cur_byte = checksum;
`endif
    else
      cur_byte = snapshot[payload_base +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      data_out <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_cnt <= '0;
      snapshot <= '0;
`ifdef DEBUG_FRAME_CHECKSUM_EN
      checksum <= 8'h00;
`endif
    end else begin
      tx_start <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          byte_cnt <= '0;
          if (start) begin
            snapshot <= {pc, Latches_1_2, Latches_2_3, Latches_3_4, Latches_4_5};
`ifdef DEBUG_FRAME_CHECKSUM_EN
            checksum <= 8'h00;
`endif
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          tx_start <= 1'b1;
          data_out <= cur_byte;
`ifdef DEBUG_FRAME_CHECKSUM_EN
          if (is_payload)
            checksum <= checksum ^ cur_byte;
`endif
          state    <= WAIT;
        end
        // data_out is left untouched here so the UART sees a stable byte
        WAIT: begin
          if (tx_done) begin
            if (byte_cnt == CNT_W'(LAST)) begin
              done  <= 1'b1;
              state <= FINISH;
            end else begin
              byte_cnt <= byte_cnt + 1'b1;
              state    <= SEND;
            end
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_frame_tx.sv
// Directed bench for debug_frame_tx: a queue of expected frame bytes is filled at each start
// and drained as the DUT raises tx_start.
module tb_debug_frame_tx;

  localparam int LEN    = 32;
  localparam int NB_L12 = 8;
  localparam int NB_L23 = 16;
  localparam int NB_L34 = 16;
  localparam int NB_L45 = 12;
`ifdef DEBUG_FRAME_CHECKSUM_EN
  localparam int FRAME_LEN = 58;
`else
  localparam int FRAME_LEN = 57;
`endif

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic                tx_done;
  logic [LEN-1:0]      pc;
  logic [NB_L12*8-1:0] l12;
  logic [NB_L23*8-1:0] l23;
  logic [NB_L34*8-1:0] l34;
  logic [NB_L45*8-1:0] l45;
  logic                tx_start;
  logic [7:0]          data_out;
  logic                busy;
  logic                done;

  logic [7:0] sb[$];
  int pass_count  = 0;
  int check_count = 0;
  int done_count  = 0;

  debug_frame_tx #(
    .LEN(LEN), .NB_L12(NB_L12), .NB_L23(NB_L23), .NB_L34(NB_L34), .NB_L45(NB_L45)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .pc(pc),
    .Latches_1_2(l12), .Latches_2_3(l23), .Latches_3_4(l34), .Latches_4_5(l45),
    .tx_done(tx_done), .tx_start(tx_start), .data_out(data_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_count++;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
  endtask

  // Reference frame built straight from the bus values at the moment start is driven
  function automatic void push_frame();
    logic [LEN+8*(NB_L12+NB_L23+NB_L34+NB_L45)-1:0] all;
    logic [7:0] b;
    logic [7:0] cs;
    all = {pc, l12, l23, l34, l45};
    cs  = 8'h00;
    sb.push_back(8'hA5);
    for (int k = 0; k < $bits(all) / 8; k++) begin
      b  = all[$bits(all)-1-8*k -: 8];
      cs = cs ^ b;
      sb.push_back(b);
    end
`ifdef DEBUG_FRAME_CHECKSUM_EN
    sb.push_back(cs);
`endif
  endfunction

  task automatic applyStimulus(input int abort_after, input int disturb_at, input bit spurious_send);
    int d0;
    int wait_cnt;
    logic [7:0] exp_b;
    d0 = done_count;
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("txs_capture_cycle", tx_start, 0);
    tx_done = spurious_send;
    tick();
    tx_done = 1'b0;
    checkOutput("first_txs_latency", tx_start, 1);
    checkOutput("cnt_first_byte", dut.byte_cnt, 0);
    for (int i = 0; i < FRAME_LEN; i++) begin
      wait_cnt = 0;
      while (tx_start !== 1'b1 && wait_cnt < 20) begin
        tick();
        wait_cnt++;
      end
      if (wait_cnt == 20) begin
        checkOutput("txs_timeout", 0, 1);
        sb.delete();
        return;
      end
      checkOutput($sformatf("txs_latency_%0d", i), wait_cnt, 0);
      exp_b = sb.pop_front();
      checkOutput($sformatf("byte_%0d", i), data_out, exp_b);
      if (i == disturb_at) begin
        pc    = '1;
        l12   = '1;
        l23   = '1;
        l34   = '1;
        l45   = '1;
        start = 1'b1;
      end
      tick();
      start = 1'b0;
      checkOutput("txs_one_cycle", tx_start, 0);
      tick();
      tick();
      checkOutput($sformatf("data_hold_%0d", i), data_out, exp_b);
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      if (i == abort_after - 1) begin
        tick();
        checkOutput("txs_before_abort", tx_start, 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("abort_tx_start", tx_start, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_data_out", data_out, 0);
        checkOutput("abort_cnt", dut.byte_cnt, 0);
        sb.delete();
        tick();
        reset = 1'b0;
        return;
      end
      if (i == FRAME_LEN - 1) begin
        checkOutput("done_pulse", done, 1);
        tick();
        checkOutput("done_clear", done, 0);
        checkOutput("busy_idle", busy, 0);
      end else begin
        checkOutput("txs_gap", tx_start, 0);
        checkOutput("no_early_done", done, 0);
        tick();
      end
    end
    checkOutput("done_count", done_count - d0, 1);
    checkOutput("sb_empty", sb.size(), 0);
  endtask

  initial begin
    int seen;
    reset   = 1'b1;
    start   = 1'b0;
    tx_done = 1'b0;
    pc      = '0;
    l12     = '0;
    l23     = '0;
    l34     = '0;
    l45     = '0;
    #1;
    checkOutput("reset_tx_start", tx_start, 0);
    checkOutput("reset_data_out", data_out, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    $display("[TB] frame with pc=0x00400010 and zero latches");
    pc = 32'h0040_0010;
    applyStimulus(0, -1, 1'b0);

    $display("[TB] spurious tx_done while idle");
    tx_done = 1'b1;
    tick();
    tick();
    tick();
    tx_done = 1'b0;
    checkOutput("idle_spurious_txs", tx_start, 0);
    checkOutput("idle_spurious_busy", busy, 0);
    checkOutput("idle_spurious_cnt", dut.byte_cnt, 0);

    $display("[TB] snapshot hold and start lockout");
    pc  = 32'h0040_0010;
    l12 = '0;
    l23 = '0;
    l34 = '0;
    l45 = '0;
    applyStimulus(0, 3, 1'b0);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (tx_start !== 1'b0 || busy !== 1'b0) seen++;
    end
    checkOutput("no_second_frame", seen, 0);

    $display("[TB] random buses with tx_done during the send cycle");
    pc  = $urandom();
    l12 = {$urandom(), $urandom()};
    l23 = {$urandom(), $urandom(), $urandom(), $urandom()};
    l34 = {$urandom(), $urandom(), $urandom(), $urandom()};
    l45 = {$urandom(), $urandom(), $urandom()};
    applyStimulus(0, -1, 1'b1);

    $display("[TB] reset mid-frame then restart");
    pc  = 32'h1234_5678;
    l12 = 64'h0102_0304_0506_0708;
    applyStimulus(10, -1, 1'b0);
    pc  = 32'hDEAD_BEEF;
    l45 = {$urandom(), $urandom(), $urandom()};
    applyStimulus(0, -1, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/debug_frame_tx.md
DEBUG_FRAME_TX -- requirements
Module: debug_frame_tx

Interface
REQ-001 SHALL have parameter LEN, default 32, giving the datapath and PC width in bits.
REQ-002 SHALL have parameter NB_L12, default 8, giving the Latches_1_2 width in bytes.
REQ-003 SHALL have parameter NB_L23, default 16, giving the Latches_2_3 width in bytes.
REQ-004 SHALL have parameter NB_L34, default 16, giving the Latches_3_4 width in bytes.
REQ-005 SHALL have parameter NB_L45, default 12, giving the Latches_4_5 width in bytes.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port start, input, 1 bit: frame request, sampled only in IDLE.
REQ-009 SHALL have port pc, input, LEN bits: MIPS program counter.
REQ-010 SHALL have ports Latches_1_2, Latches_2_3, Latches_3_4 and Latches_4_5, inputs, NB_Lxx*8 bits each: pipeline latch buses.
REQ-011 SHALL have port tx_done, input, 1 bit: UART transmitter byte-complete tick.
REQ-012 SHALL have port tx_start, output, 1 bit: one-cycle UART transmit request.
REQ-013 SHALL have port data_out, output, 8 bits: byte presented to the UART.
REQ-014 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-015 SHALL have port done, output, 1 bit: one-cycle pulse at frame end.

Function
REQ-016 SHALL implement states IDLE, SEND, WAIT and FINISH.
REQ-017 SHALL, on start=1 in IDLE, capture pc and all four latch buses into a snapshot register on the same edge and go to SEND.
REQ-018 SHALL transmit the frame in this order: header 0xA5; pc MSB first; then Latches_1_2, Latches_2_3, Latches_3_4 and Latches_4_5, each most-significant byte first.
REQ-019 SHALL give a payload of P = LEN/8+NB_L12+NB_L23+NB_L34+NB_L45 bytes (56 by default), excluding the header.
REQ-020 SHALL, in SEND, drive tx_start=1 for exactly one cycle with data_out equal to the current byte, then go to WAIT.
REQ-021 SHALL, in WAIT, hold data_out stable and keep tx_start=0 until tx_done=1.
REQ-022 SHALL, on tx_done in WAIT, go to FINISH if the last byte has been sent, otherwise advance the byte counter and go to SEND.
REQ-023 SHALL produce the next tx_start exactly 2 cycles after the tx_done edge; the first tx_start occurs 1 cycle after start is sampled.
REQ-024 SHALL, in FINISH, drive done=1 for one cycle and return to IDLE.
REQ-025 SHALL ignore start while busy=1, and SHALL leave the snapshot unchanged in that case.
REQ-026 SHALL ignore tx_done in IDLE, SEND and FINISH.
REQ-027 SHALL send only snapshot values; changes on pc or the latch buses after capture SHALL NOT affect the frame in progress.
REQ-028 SHALL size the byte counter to hold P+2 without wrapping, and SHALL clear it in IDLE.

Reset
REQ-029 SHALL, while reset=1, force state IDLE, tx_start=0, data_out=0x00, busy=0, done=0, byte counter=0, snapshot=0 and checksum=0, immediately and regardless of clk.
REQ-030 SHALL abandon any frame in progress when reset is asserted mid-frame; the next start SHALL begin again from the header.

Configuration
REQ-031 SHALL, with macro DEBUG_FRAME_CHECKSUM_EN defined, append one trailer byte equal to the XOR of the P payload bytes (header excluded), for a frame of P+2 bytes.
REQ-032 SHALL, without DEBUG_FRAME_CHECKSUM_EN, contain no checksum logic and send a frame of P+1 bytes.

Verification
REQ-033 SHALL cover reset: reset=1 at time 0 and mid-cycle -> all outputs 0 asynchronously, busy=0.
REQ-034 SHALL cover a full frame: pc=0x00400010, latches=0, one start pulse, tx_done 3 cycles after each tx_start -> bytes A5,00,40,00,10, then 52 x 00, then 0x50 (macro on); done pulses once, 1 cycle after the 58th tx_done.
REQ-035 SHALL cover snapshot and start lockout: same as REQ-034, with pc changed to 0xFFFFFFFF and start pulsed again at byte 3 -> frame unchanged, exactly one done, no second frame.
REQ-036 SHALL cover a spurious tx_done: tx_done=1 in IDLE and in the SEND cycle -> no tx_start, byte counter unchanged.
REQ-037 SHALL cover reset mid-frame: reset asserted after the 10th tx_done -> tx_start and busy low immediately; next start -> first byte 0xA5.
REQ-038 SHALL cover the macro off: REQ-034 stimulus -> 57 bytes, no 0x50 trailer, done after the 57th tx_done.
